// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared widths, ALU op encodings and operand-buffer state
package alu_operand_stage_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    typedef enum logic {EMPTY, FULL} buf_state_e;
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: issue, writeback and ALU-side operand bus of the operand stage
//   issue   : in_valid/in_ready handshake with rs1, rs2, imm, use_imm, op_in
//   wb      : wr_en, wr_addr, wr_data from the downstream stage
//   alu     : out_valid/out_ready handshake with out_a, out_b, out_op
//   master  : the side that issues, writes back and consumes (decoder/ALU/bench)
//   slave   : the operand stage itself
interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) ();
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [2:0]        op_in;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [2:0]        out_op;
    modport master (
        output in_valid, rs1, rs2, imm, use_imm, op_in, wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op
    );
    modport slave (
        input  in_valid, rs1, rs2, imm, use_imm, op_in, wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op
    );
endinterface

// File: rtl/alu_operand_stage_reg_file.sv
// reg_file_2r1w: 2**REG_AW x DATA_W register file, two bypassed read ports, one write port
//   clk, rst_n          : clock, async active-low reset (clears every entry)
//   we_i/waddr_i/wdata_i: write port, writes to index 0 are dropped
//   raddrN_i/rdataN_o   : read ports, index 0 reads 0, same-cycle write is forwarded
module reg_file_2r1w
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);
    localparam int N = 2 ** REG_AW;
    logic [DATA_W-1:0] mem_q [N];
    logic              wr_live;
    assign wr_live  = we_i && waddr_i != '0;
    assign rdata1_o = raddr1_i == '0 ? '0 : (wr_live && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = raddr2_i == '0 ? '0 : (wr_live && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (wr_live) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register-file operand fetch into a single-entry buffer feeding the ALU
//   clk, rst_n : clock, async active-low reset (drops the held entry, clears the file)
//   bus        : slave side of alu_operand_stage_if (issue, writeback, ALU operands)
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input logic          clk,
    input logic          rst_n,
    alu_operand_stage_if.slave bus
);
    buf_state_e        state_q;
    logic [DATA_W-1:0] rd1, rd2, a_q, b_q, a_d, b_d;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rs1_q, rs2_q;
    logic              use_imm_q, accept, stall, hit_a, hit_b;
    reg_file_2r1w #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (bus.wr_en),
        .waddr_i  (bus.wr_addr),
        .wdata_i  (bus.wr_data),
        .raddr1_i (bus.rs1),
        .raddr2_i (bus.rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );
    assign bus.in_ready  = state_q == EMPTY || bus.out_ready;
    assign bus.out_valid = state_q == FULL;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_op    = op_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign stall         = state_q == FULL && !bus.out_ready;
    // A held entry tracks writebacks to its source registers so it never issues stale data.
    always_comb begin
        hit_a = stall && bus.wr_en && bus.wr_addr != '0 && bus.wr_addr == rs1_q;
        hit_b = stall && bus.wr_en && bus.wr_addr != '0 && !use_imm_q && bus.wr_addr == rs2_q;
        a_d   = accept ? rd1 : hit_a ? bus.wr_data : a_q;
        b_d   = accept ? (bus.use_imm ? bus.imm : rd2) : hit_b ? bus.wr_data : b_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else begin
            state_q <= accept ? FULL : bus.out_ready ? EMPTY : state_q;
            a_q     <= a_d;
            b_q     <= b_d;
            if (accept) begin
                op_q      <= bus.op_in;
                rs1_q     <= bus.rs1;
                rs2_q     <= bus.rs2;
                use_imm_q <= bus.use_imm;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench for the operand stage (register model + held-entry queue)
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ui;
    } ent_t;
    logic        clk;
    logic        rst_n;
    logic [31:0] regs [32];
    ent_t        sb [$];
    int          n_pass = 0;
    int          n_tot = 0;
    alu_operand_stage_if bus ();
    alu_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    function automatic logic [31:0] rd(input logic [4:0] x);
        return x == 0 ? 32'h0 : (bus.wr_en && bus.wr_addr == x) ? bus.wr_data : regs[x];
    endfunction
    task automatic clr();
        bus.in_valid = 0;
        bus.wr_en    = 0;
    endtask
    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] im,
                         input logic ui, input logic [2:0] op);
        bus.in_valid = 1;
        bus.rs1      = r1;
        bus.rs2      = r2;
        bus.imm      = im;
        bus.use_imm  = ui;
        bus.op_in    = op;
    endtask
    task automatic wr(input logic [4:0] ad, input logic [31:0] d);
        bus.wr_en   = 1;
        bus.wr_addr = ad;
        bus.wr_data = d;
    endtask
    task automatic step();
        ent_t e;
        logic cons, acc;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(sb.size() == 0 || bus.out_ready));
        if (sb.size() != 0) begin
            chk("out_a", bus.out_a, sb[0].a);
            chk("out_b", bus.out_b, sb[0].b);
            chk("out_op", 32'(bus.out_op), 32'(sb[0].op));
        end
        cons = sb.size() != 0 && bus.out_ready;
        acc  = bus.in_valid && (sb.size() == 0 || bus.out_ready);
        e.a   = rd(bus.rs1);
        e.b   = bus.use_imm ? bus.imm : rd(bus.rs2);
        e.op  = bus.op_in;
        e.rs1 = bus.rs1;
        e.rs2 = bus.rs2;
        e.ui  = bus.use_imm;
        if (cons) void'(sb.pop_front());
        if (acc) sb.push_back(e);
        else if (sb.size() != 0 && bus.wr_en && bus.wr_addr != 0) begin
            if (bus.wr_addr == sb[0].rs1) sb[0].a = bus.wr_data;
            if (!sb[0].ui && bus.wr_addr == sb[0].rs2) sb[0].b = bus.wr_data;
        end
        if (bus.wr_en && bus.wr_addr != 0) regs[bus.wr_addr] = bus.wr_data;
        @(posedge clk);
        @(negedge clk);
    endtask
    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_a", bus.out_a, 32'h0);
        chk("rst_b", bus.out_b, 32'h0);
        chk("rst_op", 32'(bus.out_op), 32'h0);
        for (int i = 0; i < 32; i++) regs[i] = 0;
        sb.delete();
        wr(5, 32'hFFFF_0000);
        issue(5, 5, 0, 0, OP_ADD);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr();
        rst_n = 1;
    endtask
    initial begin
        rst_n = 1;
        bus.out_ready = 1;
        bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.use_imm = 0; bus.op_in = 0;
        bus.wr_addr = 0; bus.wr_data = 0;
        clr();
        #2 do_reset();
        step();
        wr(5, 32'h0000_0010); step();
        wr(6, 32'hFFFF_FFF0); step();
        clr(); issue(5, 6, 0, 0, OP_ADD); step();
        clr(); step();
        wr(0, 32'hDEAD_BEEF); step();
        clr(); issue(0, 0, 7, 1, OP_OR); step();
        clr(); step();
        wr(3, 32'h1234); issue(3, 0, 0, 1, OP_AND); step();
        clr(); step();
        bus.out_ready = 0;
        issue(5, 6, 0, 0, OP_SUB); step();
        issue(3, 5, 0, 0, OP_SLT);
        repeat (3) step();
        bus.out_ready = 1; step();
        clr(); step();
        step();
        bus.out_ready = 0;
        issue(1, 9, 0, 0, OP_ADD); step();
        clr(); wr(9, 32'hAA); step();
        clr(); step();
        bus.out_ready = 1; step();
        bus.out_ready = 0;
        issue(1, 9, 32'h55, 1, OP_ADD); step();
        clr(); wr(9, 32'hBB); step();
        clr(); step();
        bus.out_ready = 1; step();
        bus.out_ready = 0;
        issue(5, 6, 0, 0, OP_ADD); step();
        clr(); step();
        #2 do_reset();
        bus.out_ready = 1;
        issue(5, 5, 0, 0, OP_ADD); step();
        clr(); step();
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = 1'($urandom);
            bus.rs1       = 5'($urandom_range(0, 7));
            bus.rs2       = 5'($urandom_range(0, 7));
            bus.imm       = $urandom;
            bus.use_imm   = 1'($urandom);
            bus.op_in     = 3'($urandom);
            bus.wr_en     = 1'($urandom);
            bus.wr_addr   = 5'($urandom_range(0, 7));
            bus.wr_data   = $urandom;
            bus.out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        clr();
        bus.out_ready = 1;
        step();
        step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
